// File: rtl/ofmap_checker.sv
// Sweeps an ofmap buffer and a golden reference in lock-step and compares them lane by lane
// within a tolerance, reporting the mismatching-word count, the first bad address and sticky per-lane flags.
module ofmap_checker #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int OFMAP_ADDR_BIT = 10,
    parameter int OFMAP_NUM      = 784,
    parameter int RD_LATENCY     = 1,
    parameter int ERR_CNT_BIT    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_in,
    input  logic [OFMAP_BITWIDTH-1:0]           tol_in,
    input  logic [MAC_COL-1:0]                  lane_mask_in,
    output logic                                rd_en_out,
    output logic [OFMAP_ADDR_BIT-1:0]           rd_addr_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   rd_data_in,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   ref_data_in,
    output logic                                busy_out,
    output logic                                done_out,
    output logic [ERR_CNT_BIT-1:0]              error_cnt_out,
    output logic [OFMAP_ADDR_BIT-1:0]           first_err_addr_out,
    output logic                                first_err_valid_out,
    output logic [MAC_COL-1:0]                  lane_err_out
);

    localparam int W = OFMAP_BITWIDTH;
    localparam logic [OFMAP_ADDR_BIT-1:0] LAST_ADDR = OFMAP_ADDR_BIT'(OFMAP_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_r;
    logic [W-1:0]              tol_r;
    logic [MAC_COL-1:0]        mask_r;
    logic [RD_LATENCY-1:0]     vld_pipe_r;
    logic [OFMAP_ADDR_BIT-1:0] addr_pipe_r [RD_LATENCY];

    logic [MAC_COL-1:0]        lane_mis_s;
    logic                      word_mis_s;
    logic                      cmp_vld_s;
    logic                      cmp_last_s;
    logic [OFMAP_ADDR_BIT-1:0] cmp_addr_s;

    // Difference is taken one bit wider than the lanes so extreme signed values cannot wrap.
    function automatic logic lane_exceeds(input logic [W-1:0] dut_v,
                                          input logic [W-1:0] ref_v,
                                          input logic [W-1:0] tol_v);
        logic signed [W:0] diff;
        logic        [W:0] mag;
        diff = $signed({dut_v[W-1], dut_v}) - $signed({ref_v[W-1], ref_v});
        mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        return (mag > {1'b0, tol_v});
    endfunction

    // Per-lane tolerance compare of the word arriving at the end of the read pipeline.
    always_comb begin
        lane_mis_s = '0;
        cmp_vld_s  = vld_pipe_r[RD_LATENCY-1];
        cmp_addr_s = addr_pipe_r[RD_LATENCY-1];
        for (int i = 0; i < MAC_COL; i++) begin
            lane_mis_s[i] = cmp_vld_s & mask_r[i] &
                            lane_exceeds(rd_data_in[i*W +: W], ref_data_in[i*W +: W], tol_r);
        end
        word_mis_s = |lane_mis_s;
        cmp_last_s = cmp_vld_s && (cmp_addr_s == LAST_ADDR);
    end

    // Valid/address pipeline matching the memories' read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r <= '0;
            for (int i = 0; i < RD_LATENCY; i++) addr_pipe_r[i] <= '0;
        end else begin
            vld_pipe_r[0]  <= rd_en_out;
            addr_pipe_r[0] <= rd_addr_out;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    // Sweep control FSM together with the registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= IDLE;
            tol_r               <= '0;
            mask_r              <= '0;
            rd_en_out           <= 1'b0;
            rd_addr_out         <= '0;
            busy_out            <= 1'b0;
            done_out            <= 1'b0;
            error_cnt_out       <= '0;
            first_err_addr_out  <= '0;
            first_err_valid_out <= 1'b0;
            lane_err_out        <= '0;
        end else begin
            done_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_in) begin
                        state_r             <= ISSUE;
                        tol_r               <= tol_in;
                        mask_r              <= lane_mask_in;
                        rd_en_out           <= 1'b1;
                        rd_addr_out         <= '0;
                        busy_out            <= 1'b1;
                        error_cnt_out       <= '0;
                        first_err_addr_out  <= '0;
                        first_err_valid_out <= 1'b0;
                        lane_err_out        <= '0;
                    end
                end
                ISSUE: begin
                    if (rd_addr_out == LAST_ADDR) begin
                        state_r     <= DRAIN;
                        rd_en_out   <= 1'b0;
                        rd_addr_out <= '0;
                    end else begin
                        rd_addr_out <= rd_addr_out + OFMAP_ADDR_BIT'(1);
                    end
                end
                DRAIN: begin
                    if (cmp_last_s) begin
                        state_r  <= IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rd_en_out <= 1'b0;
                    busy_out  <= 1'b0;
                end
            endcase

            // Compares only occur while a sweep is running, so they never collide with the start clear.
            if (state_r != IDLE && word_mis_s) begin
                lane_err_out <= lane_err_out | lane_mis_s;
                if (error_cnt_out != {ERR_CNT_BIT{1'b1}}) begin
                    error_cnt_out <= error_cnt_out + ERR_CNT_BIT'(1);
                end
                if (!first_err_valid_out) begin
                    first_err_valid_out <= 1'b1;
                    first_err_addr_out  <= cmp_addr_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofmap_checker.sv
// Directed bench: a default-size checker for the full sweep cases and a small
// long-latency instance for the short-sweep / ignored-restart case.
module tb_ofmap_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b;
    logic [31:0] tol;
    logic [15:0] mask;
    int          mode;
    int          sel;
    int          n_assert = 0;
    int          n_fail   = 0;

    logic         a_rd_en, a_busy, a_done, a_fev;
    logic [9:0]   a_rd_addr, a_fea, a_q1;
    logic [511:0] a_rd_data, a_ref_data;
    logic [15:0]  a_err, a_lane;

    logic         b_rd_en, b_busy, b_done, b_fev;
    logic [9:0]   b_rd_addr, b_fea, b_q1, b_q2, b_q3;
    logic [511:0] b_rd_data, b_ref_data;
    logic [15:0]  b_err, b_lane;

    ofmap_checker dut_a (
        .clk(clk), .rst(rst), .start_in(start_a), .tol_in(tol), .lane_mask_in(mask),
        .rd_en_out(a_rd_en), .rd_addr_out(a_rd_addr), .rd_data_in(a_rd_data),
        .ref_data_in(a_ref_data), .busy_out(a_busy), .done_out(a_done),
        .error_cnt_out(a_err), .first_err_addr_out(a_fea),
        .first_err_valid_out(a_fev), .lane_err_out(a_lane)
    );

    ofmap_checker #(.OFMAP_NUM(5), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start_in(start_b), .tol_in(tol), .lane_mask_in(mask),
        .rd_en_out(b_rd_en), .rd_addr_out(b_rd_addr), .rd_data_in(b_rd_data),
        .ref_data_in(b_ref_data), .busy_out(b_busy), .done_out(b_done),
        .error_cnt_out(b_err), .first_err_addr_out(b_fea),
        .first_err_valid_out(b_fev), .lane_err_out(b_lane)
    );

    // Golden word: lane i = addr*16+i, negated on odd lanes.
    function automatic logic [511:0] ref_word(input logic [9:0] addr, input int m);
        logic [511:0] w;
        logic [31:0]  v;
        for (int i = 0; i < 16; i++) begin
            v = {22'd0, addr} * 32'd16 + 32'(i);
            w[32*i +: 32] = (i % 2 == 1) ? (32'd0 - v) : v;
        end
        if (m == 2 && addr == 10'd0) w[31:0] = 32'h7FFFFFFF;
        return w;
    endfunction

    function automatic logic [511:0] dut_word(input logic [9:0] addr, input int m);
        logic [511:0] w;
        w = ref_word(addr, m);
        if (m == 1 && addr == 10'd100) w[127:96]  = w[127:96] + 32'd1;
        if (m == 1 && addr == 10'd500) w[511:480] = w[511:480] - 32'd7;
        if (m == 2 && addr == 10'd0)   w[31:0]    = 32'h80000000;
        if (m == 3)                    w          = ~w;
        return w;
    endfunction

    // Synchronous memory models with the latency each instance expects.
    always @(posedge clk) begin
        a_q1 <= a_rd_addr;
        b_q1 <= b_rd_addr;
        b_q2 <= b_q1;
        b_q3 <= b_q2;
    end

    always_comb begin
        a_rd_data  = dut_word(a_q1, mode);
        a_ref_data = ref_word(a_q1, mode);
        b_rd_data  = dut_word(b_q3, mode);
        b_ref_data = ref_word(b_q3, mode);
    end

    logic        m_en, m_busy, m_done, m_fev;
    logic [9:0]  m_addr, m_fea;
    logic [15:0] m_err, m_lane;
    always_comb begin
        m_en   = (sel == 1) ? b_rd_en   : a_rd_en;
        m_busy = (sel == 1) ? b_busy    : a_busy;
        m_done = (sel == 1) ? b_done    : a_done;
        m_fev  = (sel == 1) ? b_fev     : a_fev;
        m_addr = (sel == 1) ? b_rd_addr : a_rd_addr;
        m_fea  = (sel == 1) ? b_fea     : a_fea;
        m_err  = (sel == 1) ? b_err     : a_err;
        m_lane = (sel == 1) ? b_lane    : a_lane;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        start_a = (sel == 0) ? v : 1'b0;
        start_b = (sel == 1) ? v : 1'b0;
    endtask

    // Runs one sweep; cycle numbers are relative to the start cycle T.
    task automatic sweep(input int n, input logic [31:0] t, input logic [15:0] mk,
                         input int extra_start, input int rst_at,
                         output int done_cyc, output int en_cnt, output int bad_addr,
                         output logic busy1, output logic busy_at_done);
        done_cyc = 0; en_cnt = 0; bad_addr = 0; busy1 = 1'b0; busy_at_done = 1'b1;
        @(negedge clk);
        tol = t; mask = mk; drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        tol = 32'd0; mask = 16'd0;
        for (int cyc = 1; cyc <= 900; cyc++) begin
            if (m_en) begin
                en_cnt++;
                if (m_addr != 10'(cyc - 1) || cyc > n) bad_addr++;
            end
            if (cyc == 1) busy1 = m_busy;
            if (m_done && done_cyc == 0) begin
                done_cyc = cyc;
                busy_at_done = m_busy;
            end
            if (rst_at > 0 && cyc == rst_at + 1)
                check("reset_midsweep_outputs",
                      {m_en, m_addr, m_busy, m_done, m_err, m_fea, m_fev, m_lane}, 64'd0);
            if (done_cyc != 0 && cyc >= done_cyc + 2) break;
            drive_start(cyc == extra_start);
            rst = (cyc == rst_at);
            @(negedge clk);
        end
        drive_start(1'b0);
        rst = 1'b0;
    endtask

    int   dc, ec, ba;
    logic b1, bd;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tol = 32'd0; mask = 16'd0;
        mode = 0; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_a", {a_rd_en, a_rd_addr, a_busy, a_done, a_err, a_fea, a_fev, a_lane}, 64'd0);
        check("reset_b", {b_rd_en, b_rd_addr, b_busy, b_done, b_err, b_fea, b_fev, b_lane}, 64'd0);

        // Identical memories, exact compare.
        sweep(784, 32'd0, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("clean_done_cycle", 64'(dc), 64'd786);
        check("clean_read_count", 64'(ec), 64'd784);
        check("clean_addr_seq",   64'(ba), 64'd0);
        check("clean_busy_t1",    64'(b1), 64'd1);
        check("clean_busy_done",  64'(bd), 64'd0);
        check("clean_results", {a_err, a_fev, a_lane}, 64'd0);

        mode = 1;
        sweep(784, 32'd0, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("two_err_done",  64'(dc), 64'd786);
        check("two_err_count", 64'(a_err), 64'd2);
        check("two_err_first", {a_fev, a_fea}, {53'd1, 10'd100});
        check("two_err_lanes", 64'(a_lane), 64'h8008);

        sweep(784, 32'd7, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("tol7_count", {a_err, a_fev, a_lane}, 64'd0);

        sweep(784, 32'd6, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("tol6_count", 64'(a_err), 64'd1);
        check("tol6_first", {a_fev, a_fea}, {53'd1, 10'd500});
        check("tol6_lanes", 64'(a_lane), 64'h8000);

        sweep(784, 32'd0, 16'h7FF7, 0, 0, dc, ec, ba, b1, bd);
        check("masked_count", {a_err, a_fev, a_lane}, 64'd0);

        mode = 2;
        sweep(784, 32'hFFFFFFFE, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("nowrap_count", 64'(a_err), 64'd1);
        check("nowrap_first", {a_fev, a_fea}, {53'd1, 10'd0});
        check("nowrap_lanes", 64'(a_lane), 64'h0001);

        sweep(784, 32'hFFFFFFFF, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("maxtol_count", {a_err, a_fev, a_lane}, 64'd0);

        // Reset in cycle T+50 of a sweep that already logged an error.
        sweep(784, 32'd0, 16'hFFFF, 0, 50, dc, ec, ba, b1, bd);
        check("reset_no_done", 64'(dc), 64'd0);

        mode = 0;
        sweep(784, 32'd0, 16'hFFFF, 0, 0, dc, ec, ba, b1, bd);
        check("post_reset_done",  64'(dc), 64'd786);
        check("post_reset_reads", 64'(ec), 64'd784);
        check("post_reset_clean", {a_err, a_fev, a_lane}, 64'd0);

        // Short sweep, latency 3, every word wrong, restart attempt at T+3.
        sel = 1; mode = 3;
        sweep(5, 32'd0, 16'hFFFF, 3, 0, dc, ec, ba, b1, bd);
        check("lat3_done_cycle", 64'(dc), 64'd9);
        check("lat3_read_count", 64'(ec), 64'd5);
        check("lat3_addr_seq",   64'(ba), 64'd0);
        check("lat3_busy_done",  64'(bd), 64'd0);
        check("lat3_err_count",  64'(b_err), 64'd5);
        check("lat3_first",      {b_fev, b_fea}, {53'd1, 10'd0});
        check("lat3_lanes",      64'(b_lane), 64'hFFFF);
        repeat (5) @(negedge clk);
        check("lat3_hold", {b_busy, b_err, b_lane}, {31'd0, 1'b0, 16'd5, 16'hFFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ofmap_checker.md
OFMAP_CHECKER -- requirements
Module: ofmap_checker

Interface
REQ-001 SHALL have parameter MAC_COL, default 16, number of 32-bit output lanes per ofmap word.
REQ-002 SHALL have parameter OFMAP_BITWIDTH, default 32, bits per lane.
REQ-003 SHALL have parameter OFMAP_ADDR_BIT, default 10, width of the ofmap word address.
REQ-004 SHALL have parameter OFMAP_NUM, default 784, number of words swept; range 1..2**OFMAP_ADDR_BIT.
REQ-005 SHALL have parameter RD_LATENCY, default 1, cycles from rd_en_out to valid rd_data_in/ref_data_in; range 1..4.
REQ-006 SHALL have parameter ERR_CNT_BIT, default 16, error counter width.
REQ-007 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-009 start_in  in  1  one-cycle pulse to begin a sweep.
REQ-010 tol_in  in  OFMAP_BITWIDTH  unsigned max allowed |dut-ref| per lane; sampled with start_in.
REQ-011 lane_mask_in  in  MAC_COL  1 = lane compared; sampled with start_in.
REQ-012 rd_en_out  out  1  read strobe to DUT ofmap buffer and reference ROM.
REQ-013 rd_addr_out  out  OFMAP_ADDR_BIT  word address, shared by both memories.
REQ-014 rd_data_in  in  MAC_COL*OFMAP_BITWIDTH  DUT word; lane i at bits [W*(i+1)-1 : W*i].
REQ-015 ref_data_in  in  MAC_COL*OFMAP_BITWIDTH  golden word, same packing.
REQ-016 busy_out  out  1  sweep in progress.
REQ-017 done_out  out  1  one-cycle pulse at sweep end.
REQ-018 error_cnt_out  out  ERR_CNT_BIT  mismatching words this sweep.
REQ-019 first_err_addr_out  out  OFMAP_ADDR_BIT  address of first mismatching word.
REQ-020 first_err_valid_out  out  1  first_err_addr_out is valid.
REQ-021 lane_err_out  out  MAC_COL  sticky per-lane mismatch flags.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, DRAIN; start_in in IDLE -> ISSUE next edge; ISSUE -> DRAIN after address OFMAP_NUM-1 issued; DRAIN -> IDLE after final compare committed.
REQ-023 start_in sampled high in cycle T (IDLE) SHALL clear error_cnt_out, first_err_valid_out, lane_err_out, latch tol_in and lane_mask_in, and assert busy_out from T+1.
REQ-024 rd_en_out SHALL be high exactly in cycles T+1..T+OFMAP_NUM with rd_addr_out = 0,1,...,OFMAP_NUM-1, one address per cycle, no gaps.
REQ-025 Data for the address issued in cycle C SHALL be compared in cycle C+RD_LATENCY via an internal RD_LATENCY-deep valid/address pipeline.
REQ-026 Lane i SHALL mismatch when lane_mask[i]=1 and |signed(dut_i) - signed(ref_i)|, computed in OFMAP_BITWIDTH+1 bits (no overflow), exceeds tol; tol=0 means exact compare.
REQ-027 A word SHALL mismatch when any lane mismatches; error_cnt_out increments by 1 per mismatching word and saturates at all-ones.
REQ-028 On the first mismatching word of a sweep, first_err_addr_out SHALL capture its address and first_err_valid_out SHALL set; later mismatches do not alter them.
REQ-029 lane_err_out[i] SHALL set on any mismatch in lane i and hold until next start or reset.
REQ-030 Compare results SHALL be visible on outputs the cycle after the compare cycle; done_out SHALL pulse in cycle T+OFMAP_NUM+RD_LATENCY+1, in which busy_out is already 0 and all results are final.
REQ-031 start_in while busy_out=1 SHALL be ignored with no effect on sweep or results.
REQ-032 start_in in the same cycle as done_out SHALL start a new sweep (FSM in IDLE).
REQ-033 Results SHALL hold after done_out until next accepted start or reset.
REQ-034 rd_data_in/ref_data_in SHALL be ignored outside compare cycles.

Reset
REQ-035 rst high at a clock edge SHALL force IDLE, rd_en_out=0, rd_addr_out=0, busy_out=0, done_out=0, error_cnt_out=0, first_err_addr_out=0, first_err_valid_out=0, lane_err_out=0, flush the valid pipeline; mid-sweep reset SHALL abort without done_out.
REQ-036 rst SHALL override start_in in the same cycle.

Verification
REQ-037 Defaults, identical memories, mask all ones, tol=0 -> 784 reads addr 0..783, done_out at T+786, error_cnt_out=0, first_err_valid_out=0, lane_err_out=0.
REQ-038 DUT word 100 lane 3 = ref+1, word 500 lane 15 = ref-7, tol=0 -> error_cnt_out=2, first_err_addr_out=100, lane_err_out=16'h8008.
REQ-039 Same data, tol=7 -> error_cnt_out=0; tol=0, lane_mask_in=16'h7FF7 -> error_cnt_out=0.
REQ-040 Lane ref=32'h7FFFFFFF, dut=32'h80000000, tol=32'hFFFFFFFE -> mismatch detected (no wrap).
REQ-041 RD_LATENCY=3, OFMAP_NUM=5, every word mismatching -> error_cnt_out=5, done_out at T+9; second start_in at T+3 ignored.
REQ-042 rst at T+50 mid-sweep -> all outputs zero next cycle, no done_out; subsequent start_in runs a clean full sweep.
